// File: rtl/seq_div_32.sv
// Sequential 32-bit unsigned restoring divider: one quotient bit per clock,
// using a ripple-carry add/subtract unit for the trial subtraction.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module RC_ADD_SUB_32 (
    input  logic        SnA,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] S,
    output logic        CO
);

    // Ripple chain: SnA=1 computes A + ~B + 1, so CO=1 means A >= B.
    always_comb begin : ripple
        logic c;
        logic b_i;
        c   = SnA;
        b_i = 1'b0;
        S   = 32'd0;
        for (int i = 0; i < 32; i++) begin
            b_i  = B[i] ^ SnA;
            S[i] = A[i] ^ b_i ^ c;
            c    = (A[i] & b_i) | (A[i] & c) | (b_i & c);
        end
        CO = c;
    end

endmodule

module seq_div_32 #(
    parameter int WIDTH = `DATA_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_ZERO
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;

    logic [WIDTH-1:0] shift_s;
    logic [WIDTH-1:0] diff_s;
    logic             co_s;
    logic             success_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;

    assign shift_s = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};

    RC_ADD_SUB_32 u_sub (
        .SnA (1'b1),
        .A   (shift_s),
        .B   (div_r),
        .S   (diff_s),
        .CO  (co_s)
    );

    // A set R[31] means the shifted value exceeds 2^32 > D, so the step
    // succeeds even though the carry-out is lost.
    always_comb begin
        success_s  = rem_r[WIDTH-1] | co_s;
        quo_next_s = {quo_r[WIDTH-2:0], success_s};
        if (success_s) begin
            rem_next_s = diff_s;
        end else begin
            rem_next_s = shift_s;
        end
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            rem_r     <= ZERO;
            quo_r     <= ZERO;
            div_r     <= ZERO;
            QUOTIENT  <= ZERO;
            REMAINDER <= ZERO;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            DIV_ZERO  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, FIN: begin
                    if (START) begin
                        if (DIVISOR == ZERO) begin
                            state_r   <= FIN;
                            BUSY      <= 1'b0;
                            DONE      <= 1'b1;
                            QUOTIENT  <= ALL_ONE;
                            REMAINDER <= DIVIDEND;
                            DIV_ZERO  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            div_r   <= DIVISOR;
                            quo_r   <= DIVIDEND;
                            rem_r   <= ZERO;
                            cnt_r   <= {CW{1'b0}};
                            BUSY    <= 1'b1;
                            DONE    <= 1'b0;
                        end
                    end else begin
                        state_r <= IDLE;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b0;
                    end
                end
                RUN: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r   <= FIN;
                        BUSY      <= 1'b0;
                        DONE      <= 1'b1;
                        QUOTIENT  <= quo_next_s;
                        REMAINDER <= rem_next_s;
                        DIV_ZERO  <= 1'b0;
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    BUSY    <= 1'b0;
                    DONE    <= 1'b0;
                end
            endcase
        end
    end

endmodule
